arbiter_wrr_hold: RTL

Weighted round-robin arbiter with registered one-hot grant and burst tenure.
- Each requester holds the grant for up to its programmed weight in accepted beats (ack), then priority rotates past it.
- Intended for shared-bus or shared-port muxing, where a granted master must keep the path for a multi-beat burst.
- Generalises plain single-cycle round robin with per-requester weights, a grant handshake, early release and back-to-back re-arbitration.

---
 rtl/arbiter_wrr_hold_pkg.sv | 21 ++
 rtl/arbiter_wrr_hold_fixed_prio.sv | 12 +
 rtl/arbiter_wrr_hold.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arbiter_wrr_hold_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter with burst tenure.
// Holds the state encoding, a clog2 helper and the weight-slice extraction macro.
package arbiter_wrr_hold_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int arb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

`ifndef ARB_WSLICE
`define ARB_WSLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

// File: rtl/arbiter_wrr_hold_fixed_prio.sv
// Combinational lowest-index-wins picker: returns the one-hot of the lowest set bit of req.
module arbiter_fixed_prio_lsb #(
    parameter int REQ_WIDTH = 8
) (
    input  logic [REQ_WIDTH-1:0] req,
    output logic [REQ_WIDTH-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + REQ_WIDTH'(1));

endmodule

// File: rtl/arbiter_wrr_hold.sv
// Weighted round-robin arbiter; an owner keeps the grant for up to weight acked beats.
// Optional macro ARB_WRR_LOCK_EN adds a lock input that stops credit exhaustion ending a tenure.
module arbiter_wrr_hold
    import arbiter_wrr_hold_pkg::*;
#(
    parameter int REQ_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ID_WIDTH     = arb_clog2(REQ_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [REQ_WIDTH-1:0]              req,
    input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
    input  logic                              ack,
`ifdef ARB_WRR_LOCK_EN
    input  logic                              lock,
`endif
    output logic [REQ_WIDTH-1:0]              gnt,
    output logic [ID_WIDTH-1:0]               gnt_id,
    output logic                              busy
);

    arb_state_t               state, state_nxt;
    logic [REQ_WIDTH-1:0]     gnt_nxt, mask, mask_nxt, mask_new, sel_mask;
    logic [REQ_WIDTH-1:0]     req_c, req_msk, pick_m, pick_u, win;
    logic [ID_WIDTH-1:0]      gnt_id_nxt, win_id;
    logic [WEIGHT_WIDTH-1:0]  credit, credit_nxt, wload;
    logic                     lock_on, release_req, exhaust;

`ifdef ARB_WRR_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign release_req = (state == GRANT) && ~|(req & gnt);
    assign exhaust     = (state == GRANT) && ack && (credit == WEIGHT_WIDTH'(1)) && !lock_on;

    // Mask after the current owner's tenure: only bits strictly above the owner stay set.
    always_comb begin
        mask_new = '0;
        for (int i = 0; i < REQ_WIDTH; i++)
            mask_new[i] = (i > int'(gnt_id));
    end

    // An early-releasing owner is removed from the candidate set for its own successor.
    assign req_c    = release_req ? (req & ~gnt) : req;
    assign sel_mask = (state == GRANT) ? mask_new : mask;
    assign req_msk  = req_c & sel_mask;

    arbiter_fixed_prio_lsb #(.REQ_WIDTH(REQ_WIDTH)) u_pick_m (.req(req_msk), .gnt(pick_m));
    arbiter_fixed_prio_lsb #(.REQ_WIDTH(REQ_WIDTH)) u_pick_u (.req(req_c),   .gnt(pick_u));

    assign win = (|req_msk) ? pick_m : pick_u;

    always_comb begin
        win_id = '0;
        wload  = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (win[i]) begin
                win_id = ID_WIDTH'(i);
                wload  = `ARB_WSLICE(weight, i, WEIGHT_WIDTH);
            end
        end
        if (wload == '0) wload = WEIGHT_WIDTH'(1);
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        credit_nxt = credit;
        mask_nxt   = mask;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = win;
                    gnt_id_nxt = win_id;
                    credit_nxt = wload;
                end
            end
            GRANT: begin
                if (release_req || exhaust) begin
                    mask_nxt = mask_new;
                    if (|win) begin
                        gnt_nxt    = win;
                        gnt_id_nxt = win_id;
                        credit_nxt = wload;
                    end else begin
                        state_nxt  = IDLE;
                        gnt_nxt    = '0;
                        gnt_id_nxt = '0;
                        credit_nxt = '0;
                    end
                end else if (ack && credit > WEIGHT_WIDTH'(1)) begin
                    credit_nxt = credit - WEIGHT_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            credit <= '0;
            mask   <= '1;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            credit <= credit_nxt;
            mask   <= mask_nxt;
        end
    end

    assign busy = (state == GRANT);

endmodule
